// File: rtl/pc_lut_prog_if.sv
// Bus bundle for pc_lut_prog: lookup port, write port, flush and FSM debug state.
// Handshake: a write is accepted on any edge where ready && wr_en && !flush; wr_ack pulses the following cycle.
interface pc_lut_prog_if #(
    parameter int D = 12,
    parameter int A = 5
);
    logic         flush;
    logic [A-1:0] rd_addr;
    logic [D-1:0] rd_target;
    logic         rd_valid;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         wr_ack;
    logic         ready;
    logic [0:0]   dbg_state;

    modport master (
        output flush, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_target, rd_valid, wr_ack, ready, dbg_state
    );

    modport slave (
        input  flush, rd_addr, wr_en, wr_addr, wr_data,
        output rd_target, rd_valid, wr_ack, ready, dbg_state
    );
endinterface

// File: rtl/pc_lut_prog.sv
// Programmable branch-target lookup table with sequential clear after reset/flush.
// Optional macro PC_LUT_BYPASS_EN forwards a same-cycle accepted write to the read port.
module pc_lut_prog #(
    parameter int D = 12,
    parameter int A = 5
) (
    input  logic         clk,
    input  logic         reset,
    pc_lut_prog_if.slave bus
);
    localparam int N = 1 << A;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t       state;
    logic [A-1:0] clr_ptr;
    logic [D-1:0] tgt_mem [N];
    logic [N-1:0] vld;
    logic         ready_q;
    logic         ack_q;

    // Reset and flush share one path: both restart clearing from entry 0.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    tgt_mem[clr_ptr] <= '0;
                    vld[clr_ptr]     <= 1'b0;
                    clr_ptr          <= clr_ptr + 1'b1;
                    ack_q            <= 1'b0;
                    if (clr_ptr == A'(N - 1)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    ack_q <= bus.wr_en;
                    if (bus.wr_en) begin
                        tgt_mem[bus.wr_addr] <= bus.wr_data;
                        vld[bus.wr_addr]     <= 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                    ready_q <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    // Reads are gated by ready so stale contents never leak out while clearing.
    always_comb begin
        bus.rd_target = '0;
        bus.rd_valid  = 1'b0;
        if (ready_q && vld[bus.rd_addr]) begin
            bus.rd_target = tgt_mem[bus.rd_addr];
            bus.rd_valid  = 1'b1;
        end
`ifdef PC_LUT_BYPASS_EN
        if (ready_q && !reset && !bus.flush && bus.wr_en && (bus.wr_addr == bus.rd_addr)) begin
            bus.rd_target = bus.wr_data;
            bus.rd_valid  = 1'b1;
        end
`endif
    end

    assign bus.ready     = ready_q;
    assign bus.wr_ack    = ack_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_pc_lut_prog.sv
// Directed self-checking bench for pc_lut_prog (D=12, A=5, N=32).
module tb_pc_lut_prog;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [31:0] exp_q[$];

    pc_lut_prog_if #(.D(12), .A(5)) bus ();

    pc_lut_prog #(.D(12), .A(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timed out, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [11:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic expect_read(input string tag, input logic [4:0] addr,
                               input logic [11:0] tgt, input logic vld);
        bus.rd_addr = addr;
        #1;
        check({tag, "_tgt"}, 32'(bus.rd_target), 32'(tgt));
        check({tag, "_vld"}, 32'(bus.rd_valid), 32'(vld));
    endtask

    // 32 clearing cycles with ready low, then ready high on the 33rd.
    task automatic expect_clear_window(input string tag);
        for (int c = 1; c <= 32; c++) begin
            bus.rd_addr = 5'(c - 1);
            #1;
            check({tag, "_ready"}, 32'(bus.ready), 32'd0);
            check({tag, "_state"}, 32'(bus.dbg_state), 32'd0);
            check({tag, "_vld"}, 32'(bus.rd_valid), 32'd0);
            check({tag, "_tgt"}, 32'(bus.rd_target), 32'd0);
            tick();
        end
        check({tag, "_ready_up"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        bus.rd_addr = '0;

        // Reset for one cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_ack", 32'(bus.wr_ack), 32'd0);

        // Clear window with a write attempted at cycle 10 (must be ignored)
        for (int c = 1; c <= 32; c++) begin
            bus.rd_addr = 5'(c - 1);
            bus.wr_en   = (c == 10);
            bus.wr_addr = 5'd2;
            bus.wr_data = 12'd503;
            #1;
            check("clr_ready", 32'(bus.ready), 32'd0);
            check("clr_vld", 32'(bus.rd_valid), 32'd0);
            check("clr_tgt", 32'(bus.rd_target), 32'd0);
            check("clr_ack", 32'(bus.wr_ack), 32'd0);
            tick();
        end
        idle_inputs();
        check("ready_c33", 32'(bus.ready), 32'd1);

        // Every entry invalid after initial clear (includes the dropped addr 2 write)
        for (int a = 0; a < 32; a++) exp_q.push_back(32'd0);
        for (int a = 0; a < 32; a++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            bus.rd_addr = 5'(a);
            #1;
            check("init_tgt", 32'(bus.rd_target), e);
            check("init_vld", 32'(bus.rd_valid), 32'd0);
        end

        // Back-to-back writes and their acks
        check("ack_idle", 32'(bus.wr_ack), 32'd0);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 12'd328;
        tick();
        bus.wr_addr = 5'd18; bus.wr_data = 12'd101;
        #1;
        check("ack_w1", 32'(bus.wr_ack), 32'd1);
        tick();
        bus.wr_en = 1'b0;
        #1;
        check("ack_w2", 32'(bus.wr_ack), 32'd1);
        tick();
        check("ack_done", 32'(bus.wr_ack), 32'd0);
        expect_read("rd3", 5'd3, 12'd328, 1'b1);
        expect_read("rd18", 5'd18, 12'd101, 1'b1);
        expect_read("rd4", 5'd4, 12'd0, 1'b0);

        // Same-cycle write/read over an old value
        do_write(5'd5, 12'd282);
        tick();
        expect_read("old5", 5'd5, 12'd282, 1'b1);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 12'd315;
`ifdef PC_LUT_BYPASS_EN
        expect_read("same5", 5'd5, 12'd315, 1'b1);
`else
        expect_read("same5", 5'd5, 12'd282, 1'b1);
`endif
        tick();
        bus.wr_en = 1'b0;
        expect_read("next5", 5'd5, 12'd315, 1'b1);
        check("ack5", 32'(bus.wr_ack), 32'd1);

        // Flush with a simultaneous write: write dropped, full clear
        bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 12'd266;
        tick();
        idle_inputs();
        #1;
        check("flush_ack", 32'(bus.wr_ack), 32'd0);
        expect_clear_window("flush");
        expect_read("fl_rd3", 5'd3, 12'd0, 1'b0);
        expect_read("fl_rd7", 5'd7, 12'd0, 1'b0);
        expect_read("fl_rd5", 5'd5, 12'd0, 1'b0);

        // Reset at clr_ptr = 20 during a flush-initiated clear
        do_write(5'd9, 12'd77);
        expect_read("pre9", 5'd9, 12'd77, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("midclr_ready", 32'(bus.ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_clear_window("rst_mid");
        expect_read("post9", 5'd9, 12'd0, 1'b0);
        expect_read("post18", 5'd18, 12'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_lut_prog.md
PC_LUT_PROG -- requirements
Module: pc_lut_prog

Interface
REQ-001 SHALL have parameter D, default 12, branch-target width in bits.
REQ-002 SHALL have parameter A, default 5, table address width; depth N = 2^A entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous request to re-clear the whole table.
REQ-006 SHALL have port rd_addr  input  A  lookup index from the branch-decode stage.
REQ-007 SHALL have port rd_target  output  D  looked-up branch target, combinational from rd_addr.
REQ-008 SHALL have port rd_valid  output  1  high when the addressed entry holds a written target.
REQ-009 SHALL have port wr_en  input  1  write request, sampled each cycle.
REQ-010 SHALL have port wr_addr  input  A  entry to write.
REQ-011 SHALL have port wr_data  input  D  target value to write.
REQ-012 SHALL have port wr_ack  output  1  one-cycle pulse confirming an accepted write.
REQ-013 SHALL have port ready  output  1  high when the table is initialised and accepting writes.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-015 SHALL, in CLEAR, zero target and valid bit of entry clr_ptr each cycle and increment clr_ptr (A bits).
REQ-016 SHALL leave CLEAR for RUN on the edge where clr_ptr = N-1 is cleared; CLEAR lasts exactly N cycles.
REQ-017 SHALL drive ready = 1 only in RUN.
REQ-018 SHALL, in RUN with wr_en = 1, write wr_data into entry wr_addr and set its valid bit at that edge.
REQ-019 SHALL assert wr_ack for exactly the cycle after each accepted write; back-to-back writes give back-to-back acks.
REQ-020 SHALL ignore wr_en while in CLEAR: no entry change, no wr_ack.
REQ-021 SHALL drive rd_target = stored target and rd_valid = 1 when ready and the entry's valid bit is set; otherwise rd_target = 0, rd_valid = 0.
REQ-022 SHALL, on flush in either state, enter CLEAR with clr_ptr = 0 on the next edge; flush during CLEAR restarts clearing from entry 0.
REQ-023 SHALL give flush priority over a same-cycle wr_en: write dropped, no wr_ack.
REQ-024 SHALL, for a same-cycle write and read of one address without bypass, return the pre-write contents on rd_target/rd_valid.
REQ-025 SHALL hold any entry not being written or cleared unchanged.

Reset
REQ-026 SHALL, on reset = 1 at an edge, enter CLEAR, set clr_ptr = 0, ready = 0, wr_ack = 0; reset overrides flush and wr_en.
REQ-027 SHALL, when reset arrives mid-RUN or mid-CLEAR, restart full N-cycle clearing; prior contents SHALL read as invalid thereafter.
REQ-028 SHALL output rd_target = 0 and rd_valid = 0 throughout CLEAR after reset.

Configuration
REQ-029 SHALL, with macro PC_LUT_BYPASS_EN defined, forward a same-cycle accepted write: when ready, wr_en = 1, no flush and wr_addr = rd_addr, rd_target = wr_data and rd_valid = 1 combinationally.
REQ-030 SHALL, without PC_LUT_BYPASS_EN, contain no forwarding path and follow REQ-024.

Verification (D=12, A=5, N=32)
REQ-031 SHALL test reset for 1 cycle then idle -> ready = 0 for 32 cycles, ready = 1 on cycle 33; every rd_addr 0..31 gives rd_target = 0, rd_valid = 0.
REQ-032 SHALL test writes in RUN addr 3 = 328, addr 18 = 101, then reads -> rd_target 328 / 101 with rd_valid = 1; wr_ack pulses one cycle after each write.
REQ-033 SHALL test wr_en with addr 2 = 503 at cycle 10 after reset (CLEAR) -> no wr_ack; after ready, addr 2 reads 0, rd_valid = 0.
REQ-034 SHALL test flush together with wr_en addr 7 = 266 in RUN -> no wr_ack, ready = 0 next cycle for 32 cycles, addr 3 then reads 0 invalid.
REQ-035 SHALL test same-cycle write/read addr 5 = 315 over old value 282 -> rd_target 282 without PC_LUT_BYPASS_EN, 315 with it; 315 on the next cycle in both builds.
REQ-036 SHALL test reset asserted at clr_ptr = 20 during a flush-initiated CLEAR -> clearing restarts, ready rises exactly 32 cycles after reset deasserts.
